// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset vector and FSM state encoding for the fetch stage.
package fetch_pkg;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_INSTR_W = 16;
    localparam logic [15:0] DEF_RESET_PC = 16'h0000;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with load-over-increment priority and modulo wrap.
module fetch_pc_reg import fetch_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc <= RESET_PC;
        else if (load) pc <= target;
        else if (inc) pc <= pc + ADDR_W'(1);
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner, imem req/ack fetcher and instruction register,
// with branch redirects that squash stale in-flight fetches.
module instr_fetch_unit import fetch_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ins,
    output logic               ins_valid,
    output logic [ADDR_W-1:0]  pc,
    input  logic               advance,
    input  logic               ldPC,
    input  logic [ADDR_W-1:0]  branch_target
);
    state_t state, state_n;
    logic req_n, vld_n, pc_load, pc_inc;
    logic [ADDR_W-1:0] addr_n, pend, pend_n, tgt;
    logic [INSTR_W-1:0] ins_n;

    // A same-cycle redirect always beats the parked target
    assign tgt = ldPC ? branch_target : pend;

    fetch_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .load(pc_load), .inc(pc_inc), .target(tgt), .pc(pc)
    );

    always_comb begin
        state_n = state;
        req_n = imem_req;
        addr_n = imem_addr;
        ins_n = ins;
        vld_n = ins_valid;
        pend_n = pend;
        pc_load = 1'b0;
        pc_inc = 1'b0;
        case (state)
            S_IDLE: begin
                state_n = S_WAIT;
                req_n = 1'b1;
                addr_n = pc;
            end
            S_WAIT: begin
                if (imem_ack && ldPC) begin
                    pc_load = 1'b1;
                    addr_n = branch_target;
                end else if (imem_ack) begin
                    ins_n = imem_rdata;
                    vld_n = 1'b1;
                    req_n = 1'b0;
                    state_n = S_HOLD;
                end else if (ldPC) begin
                    pend_n = branch_target;
                    state_n = S_FLUSH;
                end
            end
            S_HOLD: begin
                if (ldPC || advance) begin
                    pc_load = ldPC;
                    pc_inc = advance;
                    addr_n = ldPC ? branch_target : pc + ADDR_W'(1);
                    vld_n = 1'b0;
                    req_n = 1'b1;
                    state_n = S_WAIT;
                end
            end
            S_FLUSH: begin
                // The outstanding request must complete before the redirect is issued
                pend_n = tgt;
                if (imem_ack) begin
                    pc_load = 1'b1;
                    addr_n = tgt;
                    state_n = S_WAIT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            imem_req <= 1'b0;
            imem_addr <= RESET_PC;
            ins <= '0;
            ins_valid <= 1'b0;
            pend <= '0;
        end else begin
            state <= state_n;
            imem_req <= req_n;
            imem_addr <= addr_n;
            ins <= ins_n;
            ins_valid <= vld_n;
            pend <= pend_n;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench; expected fetch addresses are queued as
// advances/redirects are issued and checked against each new valid instruction.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic imem_req, imem_ack, ins_valid, advance, ldPC;
    logic [15:0] imem_addr, imem_rdata, ins, pc, branch_target;
    logic [15:0] mem [0:65535];
    logic [15:0] exp_q[$];
    logic [15:0] last_exp, mon_a, paddr;
    int tests = 0, fails = 0, wcnt = 0, wait_n = 0;
    bit alt_chk = 0, pv = 0, preq = 0;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ins(ins), .ins_valid(ins_valid),
        .pc(pc), .advance(advance), .ldPC(ldPC), .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares each newly valid instruction against the scoreboard
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            pv = 0;
            preq = 0;
        end else begin
            if (ins_valid && !pv) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_fetch: got pc %h expected none", pc);
                end else begin
                    mon_a = exp_q.pop_front();
                    check("fetch_pc", pc, mon_a);
                    check("fetch_ins", ins, mem[mon_a]);
                end
            end
            if (ins_valid) check("no_req_while_valid", {15'd0, imem_req}, 16'd0);
            if (preq && !imem_ack) begin
                check("req_held", {15'd0, imem_req}, 16'd1);
                check("addr_stable", imem_addr, paddr);
            end
            if (alt_chk) check("valid_toggle", {15'd0, ins_valid}, {15'd0, !pv});
            pv = ins_valid;
            preq = imem_req;
            paddr = imem_addr;
        end
    end

    task automatic respond();
        if (imem_req) begin
            imem_ack = (wcnt == 0);
            imem_rdata = imem_ack ? mem[imem_addr] : 16'($urandom);
            if (wcnt == 0) wcnt = (wait_n < 0) ? int'($urandom_range(0, 3)) : wait_n;
            else wcnt--;
        end else begin
            imem_ack = 1'($urandom);
            imem_rdata = 16'($urandom);
        end
    endtask

    // One cycle of stimulus; the model predicts which address is delivered next
    task automatic step(input bit adv, input bit ld, input logic [15:0] tgt);
        @(negedge clk);
        #1;
        respond();
        advance = adv;
        ldPC = ld;
        branch_target = tgt;
        if (ld) begin
            if (ins_valid || exp_q.size() == 0) exp_q.push_back(tgt);
            else exp_q[exp_q.size()-1] = tgt;
            last_exp = tgt;
        end else if (adv && ins_valid) begin
            last_exp = last_exp + 16'd1;
            exp_q.push_back(last_exp);
        end
    endtask

    task automatic wait_valid(input int n);
        int k = 0;
        do begin
            step(0, 0, 16'd0);
            k++;
        end while (!ins_valid && k < n);
        if (!ins_valid) begin
            tests++;
            fails++;
            $display("FAIL wait_valid_timeout: got ins_valid 0 expected 1 within %0d cycles", n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, {15'd0, imem_req}, 16'd0);
        check({tag, "_addr"}, imem_addr, 16'h0000);
        check({tag, "_ins"}, ins, 16'h0000);
        check({tag, "_valid"}, {15'd0, ins_valid}, 16'd0);
        check({tag, "_pc"}, pc, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h8035;
        mem[1] = 16'h4035;
        mem[2] = 16'h4835;
        mem[3] = 16'h5035;
        imem_ack = 0;
        imem_rdata = 0;
        advance = 0;
        ldPC = 0;
        branch_target = 0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        exp_q.delete();
        exp_q.push_back(16'h0000);
        last_exp = 16'h0000;
        rst = 1;
        // Zero-wait memory with advance held high
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 16'd0);
            if (ins_valid) alt_chk = 1;
        end
        alt_chk = 0;
        wait_valid(6);
        // Three-cycle memory latency fetch of address 5
        wait_n = 2;
        wcnt = 2;
        step(0, 1, 16'h0005);
        wait_valid(8);
        repeat (3) step(0, 0, 16'd0);
        check("no_refetch_without_advance", {15'd0, imem_req}, 16'd0);
        // Redirect while the sequential fetch is still outstanding
        step(1, 0, 16'd0);
        step(0, 1, 16'h0040);
        wait_valid(12);
        check("flush_pc", pc, 16'h0040);
        // Simultaneous advance and redirect: redirect wins
        step(1, 1, 16'h0010);
        wait_valid(8);
        check("adv_ld_pc", pc, 16'h0010);
        // PC wrap
        wait_n = 0;
        step(0, 1, 16'hFFFF);
        wait_valid(8);
        step(1, 0, 16'd0);
        wait_valid(8);
        check("wrap_pc", pc, 16'h0000);
        // Asynchronous reset in the middle of a slow fetch
        wait_n = 3;
        wcnt = 3;
        step(1, 0, 16'd0);
        step(0, 0, 16'd0);
        @(negedge clk);
        #3;
        rst = 0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        imem_ack = 1;
        imem_rdata = 16'hDEAD;
        @(negedge clk);
        #1;
        rst = 1;
        exp_q.push_back(16'h0000);
        last_exp = 16'h0000;
        wcnt = 0;
        wait_valid(8);
        check("post_reset_pc", pc, 16'h0000);
        // Randomized traffic with random memory latency
        wait_n = -1;
        for (int i = 0; i < 1500; i++) step(1'($urandom), ($urandom % 6) == 0, 16'($urandom));
        wait_valid(20);
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
